// File: rtl/ctc_pkg.sv
// Shared definitions for the multi-channel counter/timer block.
//   CCW_* : bit positions inside a channel control word
//   chan_state_e : per-channel sequencing state
package ctc_pkg;

    localparam int unsigned CCW_VEC = 0;  // 1 = control word, 0 = vector
    localparam int unsigned CCW_RST = 1;  // software reset
    localparam int unsigned CCW_TC  = 2;  // time constant follows
    localparam int unsigned CCW_EXT = 3;  // external start (timer mode)
    localparam int unsigned CCW_RE  = 4;  // 1 = rising edge, 0 = falling edge
    localparam int unsigned CCW_PS  = 5;  // 1 = prescale PS_HI, 0 = PS_LO
    localparam int unsigned CCW_CNT = 6;  // 1 = counter mode, 0 = timer mode
    localparam int unsigned CCW_IE  = 7;  // interrupt enable

    typedef enum logic [1:0] {
        StIdle,
        StWaitTc,
        StWaitTrig,
        StRun
    } chan_state_e;

endpackage

// File: rtl/ctc_chan.sv
// One counter/timer channel: control word, time constant, prescaler, down counter,
// trigger edge detect, interrupt pending and in-service flags.
//   clk, reset          : clock, synchronous active-high reset
//   ccw_wr, tc_wr       : decoded write strobes for this channel (never both at once)
//   isr_clr             : in-service clear strobe
//   iack                : this channel won the interrupt acknowledge
//   wdata               : bus write data
//   clk_trg             : external trigger/count input (synchronous)
//   cnt                 : current down-counter value
//   tc_follow           : next write to this channel is a time constant
//   pending, in_service : interrupt status
//   zc_to               : one-cycle zero-count pulse
module ctc_chan
    import ctc_pkg::*;
#(
    parameter int unsigned DWID  = 8,
    parameter int unsigned PS_LO = 16,
    parameter int unsigned PS_HI = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ccw_wr,
    input  logic            tc_wr,
    input  logic            isr_clr,
    input  logic            iack,
    input  logic [DWID-1:0] wdata,
    input  logic            clk_trg,
    output logic [DWID-1:0] cnt,
    output logic            tc_follow,
    output logic            pending,
    output logic            in_service,
    output logic            zc_to
);

    localparam int unsigned    PSW       = $clog2(PS_HI);
    localparam logic [PSW-1:0] PS_LO_MAX = PSW'(PS_LO - 1);
    localparam logic [PSW-1:0] PS_HI_MAX = PSW'(PS_HI - 1);

    chan_state_e     state;
    // Bits 0..2 only act at write time (select, reset, TC follows), so only 7..3 are kept.
    logic [7:3]      ccw;
    logic [7:1]      ccw_new;
    logic [DWID-1:0] tc;
    logic [PSW-1:0]  ps_cnt;
    logic            trg_q;
    logic            soft_rst, hw_edge, sw_edge, edge_ev, ps_tick, dec;

    assign ccw_new  = 7'(wdata >> 1);
    assign soft_rst = ccw_wr & ccw_new[CCW_RST];
    assign hw_edge  = ccw[CCW_RE] ? (clk_trg & ~trg_q) : (~clk_trg & trg_q);
    // Flipping the edge-select bit outside software reset acts as one trigger edge.
    assign sw_edge  = ccw_wr & ~ccw_new[CCW_RST] & (ccw_new[CCW_RE] ^ ccw[CCW_RE]);
    assign edge_ev  = hw_edge | sw_edge;
    // >= rather than == so a prescale change mid-period cannot overshoot the wrap.
    assign ps_tick  = (ps_cnt >= (ccw[CCW_PS] ? PS_HI_MAX : PS_LO_MAX));

    always_comb begin
        dec = 1'b0;
        if (!soft_rst) begin
            if (state == StRun) begin
                dec = ccw[CCW_CNT] ? edge_ev : ps_tick;
            end else if (state == StWaitTrig) begin
                // In counter mode the starting edge is itself counted.
                dec = ccw[CCW_CNT] & edge_ev & ~tc_wr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            ccw        <= '0;
            tc         <= '0;
            cnt        <= '0;
            ps_cnt     <= '0;
            trg_q      <= 1'b0;
            tc_follow  <= 1'b0;
            pending    <= 1'b0;
            in_service <= 1'b0;
            zc_to      <= 1'b0;
        end else begin
            trg_q <= clk_trg;
            zc_to <= 1'b0;

            if (iack) begin
                pending    <= 1'b0;
                in_service <= 1'b1;
            end
            if (isr_clr) begin
                in_service <= 1'b0;
            end

            case (state)
                StIdle, StWaitTc: begin
                    if (tc_wr) begin
                        state <= (ccw[CCW_CNT] || ccw[CCW_EXT]) ? StWaitTrig : StRun;
                    end
                end
                StWaitTrig: begin
                    if (!tc_wr && edge_ev) begin
                        state <= StRun;
                    end
                end
                StRun: ;
                default: state <= StIdle;
            endcase

            // Prescaler restarts from zero whenever the channel enters RUN.
            if (state != StRun || ps_tick) begin
                ps_cnt <= '0;
            end else begin
                ps_cnt <= ps_cnt + 1'b1;
            end

            if (tc_wr) begin
                tc        <= wdata;
                tc_follow <= 1'b0;
                // While running, a new TC waits for the next reload.
                if (state != StRun) begin
                    cnt <= wdata;
                end
            end

            // Zero-count is applied after iack so a simultaneous one re-arms pending.
            if (dec) begin
                if (cnt == DWID'(1)) begin
                    cnt   <= tc;
                    zc_to <= 1'b1;
                    if (ccw[CCW_IE]) begin
                        pending <= 1'b1;
                    end
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end

            if (ccw_wr) begin
                ccw       <= ccw_new[7:3];
                tc_follow <= ccw_new[CCW_TC];
                if (ccw_new[CCW_RST]) begin
                    state      <= ccw_new[CCW_TC] ? StWaitTc : StIdle;
                    pending    <= 1'b0;
                    in_service <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/ctc_multi.sv
// Multi-channel counter/timer on the Z80 I/O bus with a daisy-chained interrupt.
//   clk, reset       : clock, synchronous active-high reset
//   wr_stb, rd_stb   : one-cycle bus strobes; addr selects the channel, din is write data
//   dout, dout_vld   : counter readback or interrupt vector, valid for one cycle
//   intack           : interrupt acknowledge; iei/ieo daisy chain; int_n request
//   clk_trg          : per-channel trigger/count inputs
//   zc_to            : per-channel zero-count pulses
module ctc_multi
    import ctc_pkg::*;
#(
    parameter int unsigned DWID  = 8,
    parameter int unsigned NCH   = 4,
    parameter int unsigned CHW   = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int unsigned PS_LO = 16,
    parameter int unsigned PS_HI = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_stb,
    input  logic            rd_stb,
    input  logic [CHW-1:0]  addr,
    input  logic [DWID-1:0] din,
    output logic [DWID-1:0] dout,
    output logic            dout_vld,
    input  logic            intack,
    input  logic            iei,
    output logic            ieo,
    output logic            int_n,
    input  logic [NCH-1:0]  clk_trg,
    output logic [NCH-1:0]  zc_to
);

    logic [DWID-1:0]     cnt [NCH];
    logic [NCH-1:0]      tc_follow, pending, in_service;
    logic [NCH-1:0]      ccw_wr, tc_wr, isr_clr, chan_iack;
    logic [DWID-CHW-2:0] vec_base;
    logic                vec_wr, any_act, ack_hit, ack_go;
    logic [CHW-1:0]      ack_idx;

    // A control word with every mode bit clear is the in-service clear strobe;
    // it leaves the channel's configuration untouched.
    always_comb begin
        ccw_wr  = '0;
        tc_wr   = '0;
        isr_clr = '0;
        for (int i = 0; i < NCH; i++) begin
            if (wr_stb && addr == CHW'(i)) begin
                if (tc_follow[i]) begin
                    tc_wr[i] = 1'b1;
                end else if (din[CCW_VEC]) begin
                    if (din[DWID-1:1] == '0) begin
                        isr_clr[i] = 1'b1;
                    end else begin
                        ccw_wr[i] = 1'b1;
                    end
                end
            end
        end
    end

    assign vec_wr = wr_stb & (addr == '0) & ~tc_follow[0] & ~din[CCW_VEC];

    // Lowest index wins.
    always_comb begin
        ack_hit = 1'b0;
        ack_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (pending[i] && !ack_hit) begin
                ack_hit = 1'b1;
                ack_idx = CHW'(i);
            end
        end
    end

    assign ack_go = intack & iei & ack_hit;

    always_comb begin
        chan_iack = '0;
        chan_iack[ack_idx] = ack_go;
    end

    assign any_act = (|pending) | (|in_service);
    assign int_n   = ~(iei & any_act);
    assign ieo     = iei & ~any_act;

    always_ff @(posedge clk) begin
        if (reset) begin
            dout     <= '0;
            dout_vld <= 1'b0;
            vec_base <= '0;
        end else begin
            dout_vld <= 1'b0;
            if (vec_wr) begin
                vec_base <= din[DWID-1:CHW+1];
            end
            if (ack_go) begin
                dout     <= {vec_base, ack_idx, 1'b0};
                dout_vld <= 1'b1;
            end else if (rd_stb) begin
                dout     <= cnt[addr];
                dout_vld <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        ctc_chan #(
            .DWID  (DWID),
            .PS_LO (PS_LO),
            .PS_HI (PS_HI)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .ccw_wr     (ccw_wr[g]),
            .tc_wr      (tc_wr[g]),
            .isr_clr    (isr_clr[g]),
            .iack       (chan_iack[g]),
            .wdata      (din),
            .clk_trg    (clk_trg[g]),
            .cnt        (cnt[g]),
            .tc_follow  (tc_follow[g]),
            .pending    (pending[g]),
            .in_service (in_service[g]),
            .zc_to      (zc_to[g])
        );
    end

endmodule

// File: tb/tb_ctc_multi.sv
// Self-checking bench for ctc_multi: table of counter-mode vectors plus hand-written
// sequences for timing, interrupt arbitration and reset; dout checked via a scoreboard.
module tb_ctc_multi;

    localparam int unsigned DWID = 8;
    localparam int unsigned NCH  = 4;
    localparam int unsigned CHW  = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            wr_stb = 1'b0;
    logic            rd_stb = 1'b0;
    logic [CHW-1:0]  addr = '0;
    logic [DWID-1:0] din = '0;
    logic [DWID-1:0] dout;
    logic            dout_vld;
    logic            intack = 1'b0;
    logic            iei = 1'b1;
    logic            ieo;
    logic            int_n;
    logic [NCH-1:0]  clk_trg = '0;
    logic [NCH-1:0]  zc_to;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int zc_cnt [NCH];
    logic [7:0] exp_q [$];
    logic [7:0] sb_exp;

    typedef struct packed {
        logic [1:0]  ch;
        logic [7:0]  ccw;
        logic [7:0]  tc;
        logic [15:0] edges;
        logic [7:0]  exp_cnt;
        logic [7:0]  exp_zc;
    } vec_t;

    vec_t vecs [5];

    ctc_multi #(
        .DWID  (DWID),
        .NCH   (NCH),
        .CHW   (CHW),
        .PS_LO (16),
        .PS_HI (256)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_stb   (wr_stb),
        .rd_stb   (rd_stb),
        .addr     (addr),
        .din      (din),
        .dout     (dout),
        .dout_vld (dout_vld),
        .intack   (intack),
        .iei      (iei),
        .ieo      (ieo),
        .int_n    (int_n),
        .clk_trg  (clk_trg),
        .zc_to    (zc_to)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < NCH; i++) begin
            if (zc_to[i]) zc_cnt[i]++;
        end
    end

    // Scoreboard: every dout_vld must match the oldest expected value.
    initial forever begin
        @(negedge clk);
        if (dout_vld) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got dout 0x%0h, required no output", dout);
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_dout", dout, sb_exp);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [CHW-1:0] a, input logic [7:0] d);
        wr_stb = 1'b1; addr = a; din = d;
        tick(1);
        wr_stb = 1'b0;
    endtask

    task automatic bus_rd(input logic [CHW-1:0] a, input logic [7:0] e);
        exp_q.push_back(e);
        rd_stb = 1'b1; addr = a;
        tick(1);
        rd_stb = 1'b0;
    endtask

    task automatic bus_wr_rd(input logic [CHW-1:0] a, input logic [7:0] d, input logic [7:0] e);
        exp_q.push_back(e);
        wr_stb = 1'b1; rd_stb = 1'b1; addr = a; din = d;
        tick(1);
        wr_stb = 1'b0; rd_stb = 1'b0;
    endtask

    task automatic do_ack(input logic [7:0] e);
        exp_q.push_back(e);
        intack = 1'b1;
        tick(1);
        intack = 1'b0;
    endtask

    task automatic pulse(input int ch);
        clk_trg[ch] = 1'b1;
        tick(2);
        clk_trg[ch] = 1'b0;
        tick(2);
    endtask

    task automatic wait_zc(input int ch, input int max, output int stamp);
        bit found = 1'b0;
        stamp = -1;
        for (int k = 0; k < max && !found; k++) begin
            @(negedge clk);
            if (zc_to[ch]) begin
                found = 1'b1;
                stamp = cyc;
            end
        end
        check($sformatf("zc%0d_seen", ch), 32'(found), 32'd1);
    endtask

    int t0, s1, s2, s3, z0, zsum;

    initial begin
        vecs[0] = '{ch: 2'd3, ccw: 8'h57, tc: 8'h00, edges: 16'd10, exp_cnt: 8'hF6, exp_zc: 8'd0};
        vecs[1] = '{ch: 2'd1, ccw: 8'h57, tc: 8'h05, edges: 16'd3,  exp_cnt: 8'h02, exp_zc: 8'd0};
        vecs[2] = '{ch: 2'd1, ccw: 8'h57, tc: 8'h05, edges: 16'd5,  exp_cnt: 8'h05, exp_zc: 8'd1};
        vecs[3] = '{ch: 2'd2, ccw: 8'h47, tc: 8'h02, edges: 16'd3,  exp_cnt: 8'h01, exp_zc: 8'd1};
        vecs[4] = '{ch: 2'd0, ccw: 8'h57, tc: 8'h01, edges: 16'd4,  exp_cnt: 8'h01, exp_zc: 8'd4};

        // Reset state
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_vld", dout_vld, 0);
        check("rst_int_n", int_n, 1);
        check("rst_ieo", ieo, 1);
        check("rst_zc", zc_to, 0);
        iei = 1'b0;
        #1;
        check("rst_ieo_iei0", ieo, 0);
        iei = 1'b1;
        bus_rd(0, 8'h00);

        // Ch0 timer, PS_LO, TC 4: zero count every 64 clocks
        bus_wr(0, 8'h87);
        bus_wr(0, 8'h04);
        t0 = cyc;
        check("t1_int_n_before", int_n, 1);
        wait_zc(0, 100, s1);
        check("t1_first_zc", 32'(s1 - t0), 64);
        check("t1_int_n_after", int_n, 0);
        check("t1_ieo_pending", ieo, 0);
        wait_zc(0, 100, s2);
        check("t1_period", 32'(s2 - s1), 64);
        do_ack(8'h00);
        check("t1_int_n_insvc", int_n, 0);
        bus_wr(0, 8'h03);
        tick(1);
        check("t1_int_n_stopped", int_n, 1);

        // Vector base A0, ch2 counter mode TC 3
        bus_wr(0, 8'hA0);
        bus_wr(2, 8'hD7);
        bus_wr(2, 8'h03);
        z0 = zc_cnt[2];
        pulse(2);
        pulse(2);
        check("t2_zc_early", 32'(zc_cnt[2] - z0), 0);
        pulse(2);
        check("t2_zc", 32'(zc_cnt[2] - z0), 1);
        check("t2_int_n", int_n, 0);
        do_ack(8'hA4);
        bus_wr(2, 8'h01);
        tick(1);
        check("t2_isr_cleared", int_n, 1);
        bus_wr(2, 8'h03);

        // Ch1 and ch3 pending together
        bus_wr(1, 8'hD7);
        bus_wr(1, 8'h01);
        bus_wr(3, 8'hD7);
        bus_wr(3, 8'h01);
        clk_trg[1] = 1'b1; clk_trg[3] = 1'b1;
        tick(2);
        clk_trg[1] = 1'b0; clk_trg[3] = 1'b0;
        tick(2);
        iei = 1'b0;
        #1;
        check("t3_int_n_iei0", int_n, 1);
        check("t3_ieo_iei0", ieo, 0);
        intack = 1'b1;
        tick(1);
        intack = 1'b0;
        iei = 1'b1;
        // intack and rd_stb together: vector wins
        exp_q.push_back(8'hA2);
        intack = 1'b1; rd_stb = 1'b1; addr = 2'd0;
        tick(1);
        intack = 1'b0; rd_stb = 1'b0;
        check("t3_ieo_after_ack", ieo, 0);
        bus_wr(1, 8'h01);
        tick(1);
        check("t3_int_n_ch3", int_n, 0);
        do_ack(8'hA6);
        bus_wr(3, 8'h01);
        tick(1);
        check("t3_int_n_clear", int_n, 1);
        check("t3_ieo_clear", ieo, 1);

        // Table-driven counter-mode vectors
        for (int v = 0; v < 5; v++) begin
            bus_wr(vecs[v].ch, vecs[v].ccw);
            bus_wr(vecs[v].ch, vecs[v].tc);
            z0 = zc_cnt[vecs[v].ch];
            for (int e = 0; e < int'(vecs[v].edges); e++) pulse(int'(vecs[v].ch));
            bus_rd(vecs[v].ch, vecs[v].exp_cnt);
            tick(2);
            check($sformatf("vec%0d_zc", v), 32'(zc_cnt[vecs[v].ch] - z0), 32'(vecs[v].exp_zc));
            bus_wr(vecs[v].ch, 8'h03);
        end
        check("vec_int_n", int_n, 1);

        // Software trigger and simultaneous write/read
        bus_wr(1, 8'h57);
        bus_wr(1, 8'h05);
        pulse(1);
        bus_wr_rd(1, 8'h41, 8'h04);
        bus_rd(1, 8'h03);
        bus_wr(1, 8'h51);
        bus_rd(1, 8'h02);
        bus_wr(1, 8'h03);

        // TC=0 is 256 counts
        bus_wr(3, 8'h57);
        bus_wr(3, 8'h00);
        z0 = zc_cnt[3];
        repeat (255) pulse(3);
        bus_rd(3, 8'h01);
        check("tc0_no_zc", 32'(zc_cnt[3] - z0), 0);
        pulse(3);
        bus_rd(3, 8'h00);
        check("tc0_zc", 32'(zc_cnt[3] - z0), 1);
        bus_wr(3, 8'h03);

        // TC change mid-count
        bus_wr(0, 8'h07);
        bus_wr(0, 8'h10);
        t0 = cyc;
        tick(100);
        bus_wr(0, 8'h05);
        bus_wr(0, 8'h02);
        wait_zc(0, 300, s1);
        check("t5_first", 32'(s1 - t0), 256);
        wait_zc(0, 100, s2);
        check("t5_second", 32'(s2 - s1), 32);
        wait_zc(0, 100, s3);
        check("t5_third", 32'(s3 - s2), 32);
        bus_wr(0, 8'h03);

        // Reset during RUN with pending
        bus_wr(0, 8'h87);
        bus_wr(0, 8'h01);
        wait_zc(0, 40, s1);
        check("t6_int_n_pend", int_n, 0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        check("t6_int_n", int_n, 1);
        check("t6_zc", zc_to, 0);
        check("t6_ieo", ieo, 1);
        zsum = zc_cnt[0] + zc_cnt[1] + zc_cnt[2] + zc_cnt[3];
        tick(300);
        check("t6_quiet", 32'(zc_cnt[0] + zc_cnt[1] + zc_cnt[2] + zc_cnt[3] - zsum), 0);
        bus_rd(0, 8'h00);

        tick(5);
        check("sb_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctc_multi.md
Name: ctc_multi

Overview:
- Parametrised multi-channel Z80-style Counter/Timer Circuit with NCH independent channels behind one bus port.
- Each channel has its own control word, time constant, prescaler and down counter.
- Shared interrupt vector with the channel index embedded; daisy-chain priority interrupt with acknowledge.
- Sits on the Z80 I/O bus beside the other peripherals; drives per-channel zc_to outputs.

Parameters:
- DWID, 8, data/counter width in bits.
- NCH, 4, number of channels (1..8).
- CHW, 2, channel index width, $clog2(NCH); requires DWID >= CHW+2.
- PS_LO, 16, timer prescale when CCW bit5=0.
- PS_HI, 256, timer prescale when CCW bit5=1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset; one clock, no other clock domain
- wr_stb  in  1  one-cycle bus write strobe
- rd_stb  in  1  one-cycle bus read strobe
- addr  in  CHW  channel select
- din  in  DWID  write data
- dout  out  DWID  read or vector data
- dout_vld  out  1  dout valid, one cycle
- intack  in  1  one-cycle interrupt acknowledge (M1 and IORQ)
- iei  in  1  daisy-chain enable in
- ieo  out  1  daisy-chain enable out
- int_n  out  1  active-low interrupt request
- clk_trg  in  NCH  per-channel external trigger/count input, already synchronous to clk
- zc_to  out  NCH  per-channel zero-count pulse

Behaviour:
- Reset values: dout=0, dout_vld=0, ieo=iei, int_n=1, zc_to=0.
- Internal state on reset: all channels IDLE, CCW=8'h02 (sw-reset set), TC=0, vector base=0, no interrupt pending.
- CCW bit map (unchanged from the single-channel block):
  - b0: 1=control, 0=vector
  - b1: sw-reset
  - b2: TC follows
  - b3: external start
  - b4: rising edge
  - b5: prescale 256
  - b6: counter mode
  - b7: interrupt enable
- Write decode per addressed channel:
  - If the channel's tc_follow flag is set, the byte is the TC and tc_follow clears.
  - Else if din[0]=1, the byte is the CCW; tc_follow is set when din[2]=1.
  - Else, and only when addr=0, the byte writes vector base bits [DWID-1:CHW+1]. Vector writes to addr!=0 are ignored.
- TC value 0 means 2^DWID counts.
- Channel FSM states: IDLE, WAIT_TC, WAIT_TRIG, RUN.
  - IDLE: entered on reset or on a CCW with b1=1. A CCW with b1=1 and b2=1 goes to WAIT_TC. A CCW with b1=0 and no TC pending stays IDLE until a TC is written.
  - WAIT_TC: on the TC write, load the counter.
    - Timer mode with b3=0: -> RUN on the next cycle.
    - Counter mode, or timer mode with b3=1: -> WAIT_TRIG.
  - WAIT_TRIG: the first selected clk_trg edge (b4) -> RUN. Counter mode counts this edge.
  - RUN:
    - Timer mode: decrement once every PS_LO/PS_HI clocks.
    - Counter mode: decrement on each selected clk_trg edge.
    - On a decrement from 1: counter reloads from TC, zc_to pulses for one cycle, and pending is set if b7=1.
    - A CCW with b1=1 -> IDLE next cycle. pending is cleared and the counter holds its value.
- TC written while in RUN (CCW b1=0, b2=1) is latched and used from the next reload; counting is not disturbed.
- Toggling b4 by a CCW write while not in reset counts as one edge (software trigger).
- Read: rd_stb returns the current counter of channel addr on dout with dout_vld one cycle later.
- Interrupt arbitration:
  - Channel 0 has the highest priority.
  - int_n=0 when iei=1 and any channel is pending or in service.
  - ieo=0 when iei=0 or any channel is pending or in service.
- intack with iei=1:
  - Selects the highest-priority pending channel k.
  - dout = {base, k[CHW-1:0], 1'b0} and dout_vld=1 on the next cycle.
  - Clears pending[k] and sets in_service[k].
  - in_service clears on a CCW write with b1=1 to that channel. It also clears on a write to the in-service clear strobe, which is a CCW with b0=1 and b1..b7 = 7'h00, with the channel taken from addr.
- Simultaneous events:
  - Zero-count on the same cycle as intack: pending is re-set (set wins).
  - wr_stb and rd_stb on the same cycle: both are performed.
  - intack on the same cycle as rd_stb: intack wins dout.
- reset takes priority over everything. Mid-operation reset returns to reset values on the next edge.

Decomposition:
- Package ctc_pkg holds:
  - CCW bit index localparams (CCW_VEC, CCW_RST, CCW_TC, CCW_EXT, CCW_RE, CCW_PS, CCW_CNT, CCW_IE)
  - channel FSM state enum
- Sub-module ctc_chan holds the per-channel datapath and FSM: CCW, TC, prescaler, counter, edge detect, pending. It is instantiated NCH times by generate.
- Top ctc_multi holds write decode, read mux, vector register and the priority encoder/daisy chain.

Test Plan:
- Ch0: CCW 8'h87 then TC 8'h04, timer, PS_LO. Expect zc_to[0] every 64 clk, int_n low after the first zc_to. intack then returns dout 8'h00 with vector base 0.
- Vector 8'hA0 to addr0; ch2 counter mode, CCW 8'hD7, TC 8'h03; 3 rising edges on clk_trg[2]. Expect zc_to[2] pulse and intack dout 8'hA4.
- Ch1 and ch3 pending simultaneously. First intack returns ch1 vector and ieo stays 0. After clearing ch1 in-service, the second intack returns ch3.
- TC=0 in counter mode: expect zc_to only after 256 edges. Reading at edge 10 returns 8'hF6.
- Running ch0 with TC 8'h10; write CCW 8'h05 and TC 8'h02 mid-count. Expect the current period to complete at 16 and subsequent periods at 2.
- reset asserted during RUN with pending set. Expect int_n=1, zc_to=0, and no zc_to afterwards until reprogrammed.
